reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised integer register file with an integrated scoreboard for the pipelined RV32I core. It provides NREAD combinational read ports with optional write-back bypass and one write-back port. A per-register busy bit is set when an instruction issues and cleared at write-back. The decode stage uses the busy and ready outputs to detect RAW and WAW hazards.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of registers; power of two, minimum 2. AW = clog2(NREGS).
- NREAD, 2: number of read ports, 1..4.
- BYPASS, 1: when 1, a same-cycle write-back is forwarded to the read ports.
- ZERO_REG, 1: when 1, register 0 always reads 0, is never written and is never busy.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data for each port.
- rd_busy  out  NREAD  per port: source register has a write still pending.
- issue_valid  in  1  an instruction with a destination is issuing this cycle.
- issue_rd  in  AW  destination register of the issuing instruction.
- issue_ready  out  1  issue is accepted this cycle (no WAW hazard).
- wb_valid  in  1  write-back is valid.
- wb_rd  in  AW  write-back destination.
- wb_data  in  XLEN  write-back value.
- flush  in  1  synchronous clear of all busy bits; register data is kept.
- wb_err  out  1  sticky flag: a write-back targeted a register that was not busy.

## Operation
- Storage: NREGS x XLEN data array and an NREGS-bit busy vector.
- Write: on a rising edge with wb_valid=1, mem[wb_rd] <= wb_data. This applies regardless of the busy bit and is suppressed for wb_rd=0 when ZERO_REG=1.
- Read (combinational), port i:
  - If ZERO_REG=1 and the address is 0: data = 0, busy = 0.
  - Else if BYPASS=1, wb_valid=1 and wb_rd == address: data = wb_data, busy = 0.
  - Else: data = mem[address], busy = busy[address].
- issue_ready:
  - 0 when issue_valid=1 and busy[issue_rd]=1, unless a write-back to the same register clears it this cycle (wb_valid=1 and wb_rd == issue_rd).
  - 1 otherwise.
- Busy-bit update, per register r, in priority order:
  1. flush=1: clear all bits.
  2. Accepted issue to r (issue_valid and issue_ready): set the bit.
  3. wb_valid and wb_rd == r: clear the bit.
  4. Otherwise: hold.
- Issue and write-back to the same register in the same cycle leave the busy bit set, because the new producer takes ownership.
- ZERO_REG=1: issue_rd=0 is always accepted and never sets a bit.
- wb_err: set on any edge where wb_valid=1, busy[wb_rd]=0 and wb_rd is not a hardwired zero. Flush does not clear it; only reset clears it.

## Timing
- Reset (rst=0, asynchronous):
  - All data words and busy bits go to 0 and wb_err goes to 0.
  - Outputs therefore read rd_data=0, rd_busy=0 and issue_ready=1 (combinational, driven from the cleared state).
- Read latency is 0 cycles, both combinational and bypassed.
- Written data is visible through the array from the cycle after the edge.
- A busy bit set by an issue is visible on rd_busy in the next cycle.
- Reset asserted mid-operation discards all pending busy bits. Any later write-back then sets wb_err.
- No internal path exists from rd_addr to issue_ready; the caller gates the issue on rd_busy.

## Structure
- Shared package rv_pkg: XLEN_DEFAULT, NREGS_DEFAULT, a reg_addr_t typedef (AW bits) and the REG_ZERO constant.
- One natural sub-module, reg_file_sb_scoreboard: the busy vector, issue_ready and wb_err logic.
- The data array and read/bypass muxing stay in the top level, with the read ports generated by a loop over NREAD.

## Test plan
- Reset: hold rst=0, then release. Read every register on every port -> data 0, rd_busy 0, issue_ready 1, wb_err 0.
- Write and bypass (BYPASS=1):
  - wb x5=0xDEADBEEF while rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF in the same cycle.
  - BYPASS=0 -> rd_data[0]=0 that cycle and 0xDEADBEEF the next.
- x0 protection: wb x0=0x1234, then read x0 -> 0; issue x0 -> issue_ready=1 and rd_busy stays 0.
- Scoreboard RAW/WAW:
  - Issue x7, next cycle read x7 -> rd_busy=1.
  - Issue x7 again -> issue_ready=0.
  - wb x7=0x55 -> rd_busy=0 (bypassed), and the issue of x7 in that same cycle is accepted and leaves the bit set.
- Flush and error:
  - Issue x3, flush, read x3 -> rd_busy=0.
  - Then wb x3 -> wb_err=1, which stays 1 across a later flush and clears only on rst=0.
- Parameter sweep: XLEN=64, NREGS=16, NREAD=4. Random issue/wb traffic checked against a reference model -> zero mismatches over 10k cycles.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the RV32I integer register file and scoreboard.
package rv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy tracking: issue acceptance, write-back release, flush and
// the sticky write-back-without-producer error flag.
module reg_file_sb_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             issue_ready,
  output logic             wb_err
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [NREGS-1:0] busy_d, busy_q;
  logic             wb_err_d, wb_err_q;
  logic             issue_ready_s;
  logic             wb_hard_zero_s;

  // Issue acceptance: a write-back to the same register this cycle frees the slot.
  always_comb begin
    issue_ready_s = 1'b1;
    if (issue_valid && busy_q[issue_rd] && !(wb_valid && (wb_rd == issue_rd))) begin
      issue_ready_s = 1'b0;
    end else begin
      issue_ready_s = 1'b1;
    end
  end

  // Busy-vector next state: flush beats issue, issue beats write-back.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (issue_valid && issue_ready_s && (issue_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wb_valid && (wb_rd == AW'(r))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
    if (ZERO_EN) begin
      busy_d[0] = 1'b0;
    end else begin
      busy_d[0] = busy_d[0];
    end
  end

  // Sticky error: write-back with no outstanding producer (x0 excluded when hardwired).
  always_comb begin
    wb_hard_zero_s = ZERO_EN && (wb_rd == AW'(REG_ZERO));
    if (wb_valid && !busy_q[wb_rd] && !wb_hard_zero_s) begin
      wb_err_d = 1'b1;
    end else begin
      wb_err_d = wb_err_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign busy        = busy_q;
  assign issue_ready = issue_ready_s;
  assign wb_err      = wb_err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with combinational read ports, optional write-back
// bypass and an integrated busy-bit scoreboard for hazard detection.
module reg_file_sb
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  wb_err
);

  localparam bit ZERO_EN   = (ZERO_REG != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [XLEN-1:0]  mem_d [NREGS];
  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy_vec_s;

  reg_file_sb_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG),
    .AW      (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .busy       (busy_vec_s),
    .issue_ready(issue_ready),
    .wb_err     (wb_err)
  );

  // Array write: busy state does not gate the write, only a hardwired x0 does.
  always_comb begin
    mem_d = mem_q;
    if (wb_valid && !(ZERO_EN && (wb_rd == AW'(REG_ZERO)))) begin
      mem_d[wb_rd] = wb_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Data array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   addr_s;
    logic [XLEN-1:0] data_s;
    logic            busy_s;

    assign addr_s = rd_addr[i*AW +: AW];

    // Read mux: hardwired zero, then same-cycle bypass, then the array.
    always_comb begin
      data_s = mem_q[addr_s];
      busy_s = busy_vec_s[addr_s];
      if (ZERO_EN && (addr_s == AW'(REG_ZERO))) begin
        data_s = '0;
        busy_s = 1'b0;
      end else if (BYPASS_EN && wb_valid && (wb_rd == addr_s)) begin
        data_s = wb_data;
        busy_s = 1'b0;
      end else begin
        data_s = mem_q[addr_s];
        busy_s = busy_vec_s[addr_s];
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data_s;
    assign rd_busy[i]              = busy_s;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed checks on 32-bit instances (bypass on/off) and randomized traffic on
// a 64-bit / 16-register / 4-port instance against a behavioural model.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Shared inputs for the 32-bit instances A (bypass) and B (no bypass).
  logic [9:0]  a_rd_addr;
  logic        a_iv, a_wbv, a_flush;
  logic [4:0]  a_ird, a_wbrd;
  logic [31:0] a_wbdata;
  logic [63:0] ra_data, rb_data;
  logic [1:0]  ra_busy, rb_busy;
  logic        ra_ready, rb_ready, ra_err, rb_err;

  // Inputs/outputs for the 64-bit, 16-register, 4-port instance C.
  logic [15:0]  c_rd_addr;
  logic         c_iv, c_wbv, c_flush;
  logic [3:0]   c_ird, c_wbrd;
  logic [63:0]  c_wbdata;
  logic [255:0] c_data;
  logic [3:0]   c_busy;
  logic         c_ready, c_err;

  reg_file_sb #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(ra_data), .rd_busy(ra_busy),
    .issue_valid(a_iv), .issue_rd(a_ird), .issue_ready(ra_ready),
    .wb_valid(a_wbv), .wb_rd(a_wbrd), .wb_data(a_wbdata), .flush(a_flush), .wb_err(ra_err)
  );

  reg_file_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(rb_data), .rd_busy(rb_busy),
    .issue_valid(a_iv), .issue_rd(a_ird), .issue_ready(rb_ready),
    .wb_valid(a_wbv), .wb_rd(a_wbrd), .wb_data(a_wbdata), .flush(a_flush), .wb_err(rb_err)
  );

  reg_file_sb #(.XLEN(64), .NREGS(16), .NREAD(4)) dut_c (
    .clk(clk), .rst(rst), .rd_addr(c_rd_addr), .rd_data(c_data), .rd_busy(c_busy),
    .issue_valid(c_iv), .issue_rd(c_ird), .issue_ready(c_ready),
    .wb_valid(c_wbv), .wb_rd(c_wbrd), .wb_data(c_wbdata), .flush(c_flush), .wb_err(c_err)
  );

  // Reference state for instance C.
  logic [63:0] m_mem [16];
  bit          m_busy [16];
  bit          m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    a_rd_addr = '0; a_iv = 1'b0; a_wbv = 1'b0; a_flush = 1'b0;
    a_ird = '0; a_wbrd = '0; a_wbdata = '0;
    c_rd_addr = '0; c_iv = 1'b0; c_wbv = 1'b0; c_flush = 1'b0;
    c_ird = '0; c_wbrd = '0; c_wbdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    for (int r = 0; r < 16; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic random_cycle();
    logic [63:0] exp_d;
    bit          exp_b, exp_rdy, acc;
    int          a;
    @(negedge clk);
    for (int p = 0; p < 4; p++) c_rd_addr[p*4 +: 4] = 4'($urandom_range(0, 15));
    c_iv     = ($urandom_range(0, 1) == 0);
    c_ird    = 4'($urandom_range(0, 15));
    c_wbv    = ($urandom_range(0, 9) < 4);
    c_wbrd   = 4'($urandom_range(0, 15));
    c_wbdata = {$urandom, $urandom};
    c_flush  = ($urandom_range(0, 31) == 0);
    #1;
    for (int p = 0; p < 4; p++) begin
      a = int'(c_rd_addr[p*4 +: 4]);
      if (a == 0) begin
        exp_d = '0; exp_b = 1'b0;
      end else if (c_wbv && int'(c_wbrd) == a) begin
        exp_d = c_wbdata; exp_b = 1'b0;
      end else begin
        exp_d = m_mem[a]; exp_b = m_busy[a];
      end
      check("c_rd_data", c_data[p*64 +: 64], exp_d);
      check("c_rd_busy", 64'(c_busy[p]), 64'(exp_b));
    end
    exp_rdy = !(c_iv && m_busy[c_ird] && !(c_wbv && c_wbrd == c_ird));
    check("c_issue_ready", 64'(c_ready), 64'(exp_rdy));
    check("c_wb_err", 64'(c_err), 64'(m_err));
    // Model advances with the edge that is about to sample these inputs.
    acc = c_iv && exp_rdy;
    if (c_wbv && !m_busy[c_wbrd] && c_wbrd != 4'd0) m_err = 1'b1;
    if (c_wbv && c_wbrd != 4'd0) m_mem[c_wbrd] = c_wbdata;
    if (c_flush) begin
      for (int r = 0; r < 16; r++) m_busy[r] = 1'b0;
    end else begin
      if (c_wbv) m_busy[c_wbrd] = 1'b0;
      if (acc && c_ird != 4'd0) m_busy[c_ird] = 1'b1;
    end
  endtask

  initial begin
    logic [4:0] r5;
    idle_inputs();
    do_reset();

    // Reset state: every register on both ports.
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      r5 = r[4:0];
      a_rd_addr = {r5, r5};
      #1;
      check("rst_data0", ra_data[31:0], 64'd0);
      check("rst_data1", ra_data[63:32], 64'd0);
      check("rst_busy", 64'(ra_busy), 64'd0);
    end
    check("rst_ready", 64'(ra_ready), 64'd1);
    check("rst_err", 64'(ra_err), 64'd0);

    // Write with same-cycle bypass vs. array-only read.
    @(negedge clk);
    a_wbv = 1'b1; a_wbrd = 5'd5; a_wbdata = 32'hDEADBEEF; a_rd_addr = {5'd0, 5'd5};
    #1;
    check("bypass_same", ra_data[31:0], 64'hDEADBEEF);
    check("nobypass_same", rb_data[31:0], 64'd0);
    @(negedge clk);
    a_wbv = 1'b0;
    #1;
    check("bypass_next", ra_data[31:0], 64'hDEADBEEF);
    check("nobypass_next", rb_data[31:0], 64'hDEADBEEF);

    do_reset();
    // x0 protection.
    @(negedge clk);
    a_wbv = 1'b1; a_wbrd = 5'd0; a_wbdata = 32'h1234; a_rd_addr = '0;
    #1;
    check("x0_wb_same", ra_data[31:0], 64'd0);
    @(negedge clk);
    a_wbv = 1'b0; a_iv = 1'b1; a_ird = 5'd0;
    #1;
    check("x0_read", ra_data[31:0], 64'd0);
    check("x0_issue_ready", 64'(ra_ready), 64'd1);
    @(negedge clk);
    a_iv = 1'b0;
    #1;
    check("x0_busy", 64'(ra_busy[0]), 64'd0);
    check("x0_no_err", 64'(ra_err), 64'd0);

    // RAW / WAW on x7.
    @(negedge clk);
    a_iv = 1'b1; a_ird = 5'd7; a_rd_addr = {5'd0, 5'd7};
    #1;
    check("x7_issue1_ready", 64'(ra_ready), 64'd1);
    check("x7_busy_before", 64'(ra_busy[0]), 64'd0);
    @(negedge clk);
    #1;
    check("x7_raw_busy", 64'(ra_busy[0]), 64'd1);
    check("x7_waw_ready", 64'(ra_ready), 64'd0);
    @(negedge clk);
    a_wbv = 1'b1; a_wbrd = 5'd7; a_wbdata = 32'h55;
    #1;
    check("x7_wb_ready", 64'(ra_ready), 64'd1);
    check("x7_wb_busy_byp", 64'(ra_busy[0]), 64'd0);
    check("x7_wb_data_byp", ra_data[31:0], 64'h55);
    check("x7_wb_busy_nobyp", 64'(rb_busy[0]), 64'd1);
    @(negedge clk);
    a_iv = 1'b0; a_wbv = 1'b0;
    #1;
    check("x7_still_busy", 64'(ra_busy[0]), 64'd1);
    check("x7_data", ra_data[31:0], 64'h55);
    check("x7_no_err", 64'(ra_err), 64'd0);
    @(negedge clk);
    a_wbv = 1'b1; a_wbdata = 32'h66;
    @(negedge clk);
    a_wbv = 1'b0;
    #1;
    check("x7_released", 64'(ra_busy[0]), 64'd0);
    check("x7_data2", ra_data[31:0], 64'h66);

    // Flush and sticky error.
    @(negedge clk);
    a_iv = 1'b1; a_ird = 5'd3; a_rd_addr = {5'd0, 5'd3};
    @(negedge clk);
    a_iv = 1'b0; a_flush = 1'b1;
    #1;
    check("x3_busy_pre_flush", 64'(ra_busy[0]), 64'd1);
    @(negedge clk);
    a_flush = 1'b0;
    #1;
    check("x3_busy_flushed", 64'(ra_busy[0]), 64'd0);
    @(negedge clk);
    a_wbv = 1'b1; a_wbrd = 5'd3; a_wbdata = 32'h9;
    #1;
    check("err_before_edge", 64'(ra_err), 64'd0);
    @(negedge clk);
    a_wbv = 1'b0;
    #1;
    check("err_set", 64'(ra_err), 64'd1);
    @(negedge clk);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    #1;
    check("err_after_flush", 64'(ra_err), 64'd1);
    do_reset();
    #1;
    check("err_after_rst", 64'(ra_err), 64'd0);

    // Randomized traffic on the wide instance, with periodic mid-run resets.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int n = 0; n < 2500; n++) random_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
